// File: rtl/axis_i2s_tx_if.sv
// AXI-Stream audio word channel: 32-bit data, last marks the right sample of a stereo pair.
interface axis_i2s_tx_if;
   logic [31:0] data;
   logic        valid;
   logic        ready;
   logic        last;

   modport master (output data, output valid, output last, input ready);
   modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/axis_i2s_tx.sv
// AXIS stereo pairs to Philips I2S; one pair buffered, loaded at frame start (first MSB 2*BCLK_DIV clk after enable).
// Backpressure: ready low while a complete pair waits for the next frame; silence plus underrun pulse when none is waiting.
module axis_i2s_tx #(
   parameter int BCLK_DIV = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         enable,
   axis_i2s_tx_if.slave s_axis,
   output logic         i2s_bclk,
   output logic         i2s_lrck,
   output logic         i2s_sdata,
   output logic         underrun,
   output logic         desync
);
   localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(BCLK_DIV - 1);

   typedef enum logic {WAIT_L, WAIT_R} state_t;

   state_t           state;
   logic [23:0]      pend_l;
   logic [23:0]      pend_r;
   logic             pending_full;
   logic [23:0]      tx_l;
   logic [23:0]      tx_r;
   logic [23:0]      next_l;
   logic [23:0]      next_r;
   logic [DIV_W-1:0] div_cnt;
   logic [5:0]       bit_cnt;
   logic [5:0]       next_bit;
   logic [4:0]       slot_idx;
   logic             hs;
   logic             wrap;
   logic             fall;
   logic             frame_load;
   logic             next_sd;
   logic             unused_hi;

   assign s_axis.ready = !reset && !pending_full;
   assign hs           = s_axis.valid && s_axis.ready;
   assign unused_hi    = ^s_axis.data[31:24];

   assign wrap       = (div_cnt == DIV_MAX);
   assign fall       = enable && wrap && i2s_bclk;
   assign next_bit   = bit_cnt + 6'd1;
   assign frame_load = fall && (next_bit == 6'd0);
   // Left and right slots share the same in-slot index: bits 0..23 and 32..55 both map to 23 - bit[4:0].
   assign slot_idx   = 5'd23 - next_bit[4:0];

   always_comb begin
      next_l = tx_l;
      next_r = tx_r;
      if (next_bit == 6'd0) begin
         next_l = pending_full ? pend_l : 24'd0;
         next_r = pending_full ? pend_r : 24'd0;
      end
      next_sd = 1'b0;
      if (next_bit[4:0] < 5'd24) begin
         next_sd = next_bit[5] ? next_r[slot_idx] : next_l[slot_idx];
      end
   end

   // Input pairing FSM; keeps running while the serializer is disabled.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= WAIT_L;
         pend_l       <= '0;
         pend_r       <= '0;
         pending_full <= 1'b0;
         desync       <= 1'b0;
      end else begin
         desync <= 1'b0;
         if (frame_load && pending_full) begin
            pending_full <= 1'b0;
         end
         if (hs) begin
            case (state)
               WAIT_L: begin
                  if (s_axis.last) begin
                     desync <= 1'b1;
                  end else begin
                     pend_l <= s_axis.data[23:0];
                     state  <= WAIT_R;
                  end
               end
               WAIT_R: begin
                  if (s_axis.last) begin
                     pend_r       <= s_axis.data[23:0];
                     pending_full <= 1'b1;
                     state        <= WAIT_L;
                  end else begin
                     pend_l <= s_axis.data[23:0];
                     desync <= 1'b1;
                  end
               end
            endcase
         end
      end
   end

   // Serializer: everything advances on the BCLK falling edge; bit_cnt parks at 63 so the first fall loads a frame.
   always_ff @(posedge clk) begin
      if (reset || !enable) begin
         div_cnt   <= '0;
         i2s_bclk  <= 1'b0;
         i2s_lrck  <= 1'b0;
         i2s_sdata <= 1'b0;
         bit_cnt   <= 6'd63;
         tx_l      <= '0;
         tx_r      <= '0;
         underrun  <= 1'b0;
      end else begin
         underrun <= 1'b0;
         if (wrap) begin
            div_cnt  <= '0;
            i2s_bclk <= !i2s_bclk;
         end else begin
            div_cnt <= div_cnt + DIV_W'(1);
         end
         if (fall) begin
            bit_cnt   <= next_bit;
            tx_l      <= next_l;
            tx_r      <= next_r;
            i2s_lrck  <= (next_bit >= 6'd31) && (next_bit <= 6'd62);
            i2s_sdata <= next_sd;
            underrun  <= (next_bit == 6'd0) && !pending_full;
         end
      end
   end
endmodule

// File: tb/tb_axis_i2s_tx.sv
// Bench for axis_i2s_tx: per-edge waveform expectations derived from elapsed time since enable and a queue of frame contents.
module tb_axis_i2s_tx;
   localparam int D = 2;
   localparam int NSAMP = 16384;

   typedef struct {
      logic [23:0] l;
      logic [23:0] r;
      bit          sil;
   } frm_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic enable = 1'b0;
   logic i2s_bclk, i2s_lrck, i2s_sdata, underrun, desync;

   axis_i2s_tx_if s_if ();

   axis_i2s_tx #(.BCLK_DIV(D)) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .s_axis    (s_if),
      .i2s_bclk  (i2s_bclk),
      .i2s_lrck  (i2s_lrck),
      .i2s_sdata (i2s_sdata),
      .underrun  (underrun),
      .desync    (desync)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   logic [5:0] samp [0:NSAMP-1];
   frm_t exp_q [$];

   // Sample index cyc holds {ready, desync, bclk, lrck, sdata, underrun} just after posedge number cyc.
   always begin
      @(posedge clk);
      #1;
      if (cyc < NSAMP) samp[cyc] = {s_if.ready, desync, i2s_bclk, i2s_lrck, i2s_sdata, underrun};
      cyc++;
   end

   // Expected {bclk, lrck, sdata, underrun} after edge t (t=1 is the first edge with enable high).
   function automatic logic [3:0] exp_wave(int t);
      int nf, b, k;
      logic [23:0] l, r;
      logic sil, bc, lr, sd, un;
      bc = ((t / D) % 2) == 1;
      nf = t / (2 * D);
      if (nf == 0) return {bc, 3'b000};
      b = (nf - 1) % 64;
      k = (nf - 1) / 64;
      if (k < exp_q.size() && !exp_q[k].sil) begin
         l = exp_q[k].l; r = exp_q[k].r; sil = 1'b0;
      end else begin
         l = '0; r = '0; sil = 1'b1;
      end
      lr = (b >= 31) && (b <= 62);
      if (b < 24) sd = l[23 - b];
      else if (b >= 32 && b < 56) sd = r[55 - b];
      else sd = 1'b0;
      un = sil && (b == 0) && (t % (2 * D) == 0);
      return {bc, lr, sd, un};
   endfunction

   task automatic wait_until(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; enable = 1'b0;
      s_if.valid = 1'b0; s_if.last = 1'b0; s_if.data = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   // Called at a negedge; returns at the negedge after the handshake edge.
   task automatic send_word(input logic [31:0] d, input logic lst);
      int n = 0;
      s_if.data = d; s_if.last = lst; s_if.valid = 1'b1;
      while (s_if.ready !== 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) begin
         checks++; failures++;
         $display("FAIL send_timeout got=ready_low_%0d_cycles required=handshake", n);
      end
      @(negedge clk);
      s_if.valid = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1; enable = 1'b0; s_if.valid = 1'b0; s_if.last = 1'b0; s_if.data = '0;
      @(negedge clk);
      checks++;
      if (samp[cyc-1] !== 6'b000000) begin
         failures++; $display("FAIL reset_outputs got=%b required=000000", samp[cyc-1]);
      end
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (samp[cyc-1] !== 6'b100000) begin
         failures++; $display("FAIL ready_after_reset got=%b required=100000", samp[cyc-1]);
      end
   endtask

   task automatic test_basic_frame();
      int base, n;
      logic [23:0] dl, dr;
      logic [3:0] ew;
      do_reset();
      send_word({8'($urandom), 24'h800001}, 1'b0);
      send_word({8'($urandom), 24'h7FFFFE}, 1'b1);
      exp_q.delete();
      exp_q.push_back('{24'h800001, 24'h7FFFFE, 1'b0});
      exp_q.push_back('{24'h0, 24'h0, 1'b1});
      base = cyc; enable = 1'b1;
      n = 2 * D * 65;
      wait_until(base + n);
      for (int t = 1; t <= n; t++) begin
         ew = exp_wave(t);
         checks++;
         if (samp[base+t-1][3:0] !== ew) begin
            failures++;
            $display("FAIL basic_wave t=%0d got=%b required=%b", t, samp[base+t-1][3:0], ew);
            break;
         end
      end
      for (int b = 0; b < 24; b++) begin
         dl[23-b] = samp[base + 2*D*(b+1) - 1][1];
         dr[23-b] = samp[base + 2*D*(b+33) - 1][1];
      end
      checks++;
      if (dl !== 24'h800001) begin
         failures++; $display("FAIL basic_left got=%h required=800001", dl);
      end
      checks++;
      if (dr !== 24'h7FFFFE) begin
         failures++; $display("FAIL basic_right got=%h required=7ffffe", dr);
      end
      enable = 1'b0;
      @(negedge clk);
      checks++;
      if (samp[cyc-1][3:1] !== 3'b000) begin
         failures++; $display("FAIL basic_disable got=%b required=000", samp[cyc-1][3:1]);
      end
   endtask

   task automatic test_idle_underrun();
      int base, n, pulses;
      logic [3:0] ew;
      do_reset();
      exp_q.delete();
      base = cyc; enable = 1'b1;
      n = 2 * D * (64 * 3 + 1);
      wait_until(base + n);
      pulses = 0;
      for (int t = 1; t <= n; t++) begin
         if (samp[base+t-1][0] === 1'b1) pulses++;
      end
      for (int t = 1; t <= n; t++) begin
         ew = exp_wave(t);
         checks++;
         if (samp[base+t-1][3:0] !== ew) begin
            failures++;
            $display("FAIL idle_wave t=%0d got=%b required=%b", t, samp[base+t-1][3:0], ew);
            break;
         end
      end
      checks++;
      if (pulses !== 4) begin
         failures++; $display("FAIL idle_underrun_count got=%0d required=4", pulses);
      end
      enable = 1'b0;
   endtask

   task automatic test_back_to_back();
      int base, n, l1, ds;
      logic [3:0] ew;
      frm_t p [3];
      do_reset();
      exp_q.delete();
      for (int i = 0; i < 3; i++) begin
         p[i].l = 24'($urandom); p[i].r = 24'($urandom); p[i].sil = 1'b0;
         exp_q.push_back(p[i]);
      end
      exp_q.push_back('{24'h0, 24'h0, 1'b1});
      base = cyc; enable = 1'b1;
      for (int i = 0; i < 3; i++) begin
         send_word({8'($urandom), p[i].l}, 1'b0);
         send_word({8'($urandom), p[i].r}, 1'b1);
      end
      n = 2 * D * (64 * 3 + 1);
      wait_until(base + n);
      for (int t = 1; t <= n; t++) begin
         ew = exp_wave(t);
         checks++;
         if (samp[base+t-1][3:0] !== ew) begin
            failures++;
            $display("FAIL b2b_wave t=%0d got=%b required=%b", t, samp[base+t-1][3:0], ew);
            break;
         end
      end
      l1 = 2 * D * 65;
      checks++;
      if (samp[base + l1 - 2][5] !== 1'b0) begin
         failures++; $display("FAIL b2b_ready_stalled got=%b required=0", samp[base + l1 - 2][5]);
      end
      checks++;
      if (samp[base + l1 - 1][5] !== 1'b1) begin
         failures++; $display("FAIL b2b_ready_after_load got=%b required=1", samp[base + l1 - 1][5]);
      end
      ds = 0;
      for (int t = 1; t <= n; t++) if (samp[base+t-1][4] === 1'b1) ds++;
      checks++;
      if (ds !== 0) begin
         failures++; $display("FAIL b2b_desync got=%0d required=0", ds);
      end
      enable = 1'b0;
   endtask

   task automatic test_desync();
      int st, ds, base, n;
      logic [3:0] ew;
      do_reset();
      st = cyc;
      send_word({8'($urandom), 24'h0ABCDE}, 1'b1);
      @(negedge clk);
      ds = 0;
      for (int i = st; i < cyc; i++) if (samp[i][4] === 1'b1) ds++;
      checks++;
      if (ds !== 1) begin
         failures++; $display("FAIL desync_stray_right got=%0d required=1", ds);
      end
      st = cyc;
      send_word({8'($urandom), 24'h111111}, 1'b0);
      send_word({8'($urandom), 24'h222222}, 1'b0);
      send_word({8'($urandom), 24'h333333}, 1'b1);
      @(negedge clk);
      ds = 0;
      for (int i = st; i < cyc; i++) if (samp[i][4] === 1'b1) ds++;
      checks++;
      if (ds !== 1) begin
         failures++; $display("FAIL desync_double_left got=%0d required=1", ds);
      end
      exp_q.delete();
      exp_q.push_back('{24'h222222, 24'h333333, 1'b0});
      exp_q.push_back('{24'h0, 24'h0, 1'b1});
      base = cyc; enable = 1'b1;
      n = 2 * D * 65;
      wait_until(base + n);
      for (int t = 1; t <= n; t++) begin
         ew = exp_wave(t);
         checks++;
         if (samp[base+t-1][3:0] !== ew) begin
            failures++;
            $display("FAIL desync_wave t=%0d got=%b required=%b", t, samp[base+t-1][3:0], ew);
            break;
         end
      end
      enable = 1'b0;
   endtask

   task automatic test_reset_mid_frame();
      int base, n;
      logic [3:0] ew;
      frm_t a;
      do_reset();
      a.l = 24'($urandom); a.r = 24'($urandom); a.sil = 1'b0;
      send_word({8'($urandom), a.l}, 1'b0);
      send_word({8'($urandom), a.r}, 1'b1);
      exp_q.delete();
      exp_q.push_back(a);
      base = cyc; enable = 1'b1;
      send_word({8'($urandom), 24'($urandom)}, 1'b0);
      send_word({8'($urandom), 24'($urandom)}, 1'b1);
      wait_until(base + 2 * D * 11 + 1);
      for (int t = 1; t <= 2 * D * 11; t++) begin
         ew = exp_wave(t);
         checks++;
         if (samp[base+t-1][3:0] !== ew) begin
            failures++;
            $display("FAIL rstmid_pre_wave t=%0d got=%b required=%b", t, samp[base+t-1][3:0], ew);
            break;
         end
      end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (samp[cyc-1] !== 6'b000000) begin
         failures++; $display("FAIL rstmid_outputs got=%b required=000000", samp[cyc-1]);
      end
      reset = 1'b0;
      exp_q.delete();
      base = cyc;
      n = 2 * D * 65;
      wait_until(base + n);
      checks++;
      if (samp[base][5] !== 1'b1) begin
         failures++; $display("FAIL rstmid_ready got=%b required=1", samp[base][5]);
      end
      for (int t = 1; t <= n; t++) begin
         ew = exp_wave(t);
         checks++;
         if (samp[base+t-1][3:0] !== ew) begin
            failures++;
            $display("FAIL rstmid_post_wave t=%0d got=%b required=%b", t, samp[base+t-1][3:0], ew);
            break;
         end
      end
      enable = 1'b0;
   endtask

   task automatic test_enable_drop();
      int base, n;
      logic [3:0] ew;
      frm_t a, b;
      do_reset();
      a.l = 24'($urandom); a.r = 24'($urandom); a.sil = 1'b0;
      b.l = 24'($urandom); b.r = 24'($urandom); b.sil = 1'b0;
      send_word({8'($urandom), a.l}, 1'b0);
      send_word({8'($urandom), a.r}, 1'b1);
      exp_q.delete();
      exp_q.push_back(a);
      base = cyc; enable = 1'b1;
      send_word({8'($urandom), b.l}, 1'b0);
      send_word({8'($urandom), b.r}, 1'b1);
      wait_until(base + 100);
      for (int t = 1; t <= 100; t++) begin
         ew = exp_wave(t);
         checks++;
         if (samp[base+t-1][3:0] !== ew) begin
            failures++;
            $display("FAIL endrop_pre_wave t=%0d got=%b required=%b", t, samp[base+t-1][3:0], ew);
            break;
         end
      end
      enable = 1'b0;
      @(negedge clk);
      checks++;
      if (samp[cyc-1][3:1] !== 3'b000) begin
         failures++; $display("FAIL endrop_idle got=%b required=000", samp[cyc-1][3:1]);
      end
      repeat ($urandom_range(3, 20)) @(negedge clk);
      checks++;
      if (samp[cyc-1][5] !== 1'b0) begin
         failures++; $display("FAIL endrop_pending_kept got=ready_%b required=ready_0", samp[cyc-1][5]);
      end
      exp_q.delete();
      exp_q.push_back(b);
      exp_q.push_back('{24'h0, 24'h0, 1'b1});
      base = cyc; enable = 1'b1;
      n = 2 * D * 65;
      wait_until(base + n);
      for (int t = 1; t <= n; t++) begin
         ew = exp_wave(t);
         checks++;
         if (samp[base+t-1][3:0] !== ew) begin
            failures++;
            $display("FAIL endrop_post_wave t=%0d got=%b required=%b", t, samp[base+t-1][3:0], ew);
            break;
         end
      end
      checks++;
      if (samp[base + 2*D - 1][5] !== 1'b1) begin
         failures++; $display("FAIL endrop_ready_after_load got=%b required=1", samp[base + 2*D - 1][5]);
      end
      enable = 1'b0;
   endtask

   initial begin
      s_if.valid = 1'b0; s_if.last = 1'b0; s_if.data = '0;
      repeat (3) @(negedge clk);
      test_reset();
      test_basic_frame();
      test_idle_underrun();
      test_back_to_back();
      test_desync();
      test_reset_mid_frame();
      test_enable_drop();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout required=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
